dcache_write_buffer: RTL

Posted write buffer between the data cache's memory port and the backing memory bus. Cache writes are accepted in zero wait cycles, coalesced by address, and drained to memory in FIFO order. Cache reads return buffered data directly when the address is pending, and go to the bus otherwise. The cache-facing port uses the same req/we/addr/wdata/ready/rdata handshake as the cache's memory interface, so the block drops in between the two unchanged.

---
 rtl/dcache_write_buffer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/dcache_write_buffer.sv
// dcache_write_buffer: posted, coalescing write buffer between a data cache and the memory bus
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   c_req_i, c_we_i, c_addr_i,  cache request; held until c_ready_o
//   c_wdata_i
//   c_ready_o, c_rdata_o        combinational completion and read data
//   bus_req_o, bus_we_o,        registered memory bus request
//   bus_addr_o, bus_wdata_o
//   bus_ready_i, bus_rdata_i    memory completion and read data
//   flush_i                     level; drains the buffer and holds off new bus reads
//   buf_empty_o, buf_count_o    registered occupancy status
module dcache_write_buffer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    c_req_i,
    input  logic                    c_we_i,
    input  logic [ADDR_WIDTH-1:0]   c_addr_i,
    input  logic [DATA_WIDTH-1:0]   c_wdata_i,
    output logic                    c_ready_o,
    output logic [DATA_WIDTH-1:0]   c_rdata_o,
    output logic                    bus_req_o,
    output logic                    bus_we_o,
    output logic [ADDR_WIDTH-1:0]   bus_addr_o,
    output logic [DATA_WIDTH-1:0]   bus_wdata_o,
    input  logic                    bus_ready_i,
    input  logic [DATA_WIDTH-1:0]   bus_rdata_i,
    input  logic                    flush_i,
    output logic                    buf_empty_o,
    output logic [$clog2(DEPTH):0]  buf_count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, DRAIN, READ} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q [DEPTH];
    logic [DATA_WIDTH-1:0]  data_q [DEPTH];
    logic [PW-1:0]          head_q, tail_q, idx, wr_idx;
    logic [CW-1:0]          count_q, count_d;
    logic                   bus_req_q, bus_we_q, buf_empty_q;
    logic [ADDR_WIDTH-1:0]  bus_addr_q;
    logic [DATA_WIDTH-1:0]  bus_wdata_q;
    logic                   wr_hit, rd_hit, full, wr_req, rd_req;
    logic                   enq, coal, pop, start_rd, start_dr;
    logic [DATA_WIDTH-1:0]  rd_data, drain_data;

    // Scan oldest to youngest so the last match is the youngest copy.
    // The head in flight may be forwarded from but never coalesced into.
    always_comb begin
        idx     = '0;
        wr_idx  = '0;
        wr_hit  = 1'b0;
        rd_hit  = 1'b0;
        rd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (CW'(i) < count_q && addr_q[idx] == c_addr_i) begin
                rd_hit  = 1'b1;
                rd_data = data_q[idx];
                if (!(state_q == DRAIN && i == 0)) begin
                    wr_hit = 1'b1;
                    wr_idx = idx;
                end
            end
        end
    end

    assign wr_req   = c_req_i && c_we_i;
    assign rd_req   = c_req_i && !c_we_i;
    assign full     = count_q == CW'(DEPTH);
    assign coal     = wr_req && wr_hit;
    assign enq      = wr_req && !wr_hit && !full;
    assign pop      = state_q == DRAIN && bus_ready_i;
    assign start_rd = state_q == IDLE && rd_req && !rd_hit && !full && !flush_i;
    assign start_dr = state_q == IDLE && !start_rd && count_q != '0;
    assign count_d  = count_q + CW'(enq) - CW'(pop);
    assign state_d  = start_rd ? READ :
                      start_dr ? DRAIN :
                      (state_q != IDLE && bus_ready_i) ? IDLE : state_q;
    // A coalesce into the head in the same cycle it launches must reach the bus.
    assign drain_data = (coal && wr_idx == head_q) ? c_wdata_i : data_q[head_q];

    assign c_ready_o = !rst && (wr_req ? (wr_hit || !full)
                                       : rd_req && (rd_hit || (state_q == READ && bus_ready_i)));
    assign c_rdata_o = rd_hit ? rd_data : bus_rdata_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            buf_empty_q <= 1'b1;
        end else begin
            if (enq) begin
                addr_q[tail_q] <= c_addr_i;
                data_q[tail_q] <= c_wdata_i;
                tail_q         <= tail_q + PW'(1);
            end
            if (coal)
                data_q[wr_idx] <= c_wdata_i;
            if (pop)
                head_q <= head_q + PW'(1);
            if (start_rd) begin
                bus_we_q   <= 1'b0;
                bus_addr_q <= c_addr_i;
            end
            if (start_dr) begin
                bus_we_q    <= 1'b1;
                bus_addr_q  <= addr_q[head_q];
                bus_wdata_q <= drain_data;
            end
            count_q     <= count_d;
            state_q     <= state_d;
            bus_req_q   <= state_d != IDLE;
            buf_empty_q <= count_d == '0 && state_d == IDLE;
        end
    end

    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;
    assign buf_empty_o = buf_empty_q;
    assign buf_count_o = count_q;
endmodule
